io_out_capture: RTL and testbench

Captures the CPU's output-port words (`out`, qualified by `outFlag`) into an on-chip FIFO and drains them to a downstream consumer over a valid/ready handshake. It also generates the CPU's `startIO` enable after a programmable post-reset delay. It sits directly downstream of the CPU output port and replaces ad-hoc capture logic around the core.

---
 rtl/io_out_pkg.sv | 15 +
 rtl/io_out_fifo.sv | 68 ++++++
 rtl/io_out_capture.sv | 112 +++++++++++
 tb/tb_io_out_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_out_pkg.sv
// Shared types and helpers for the CPU output-port capture block.
package io_out_pkg;

    // Start sequencer: hold off the CPU I/O enable, then run until reset.
    typedef enum logic [0:0] {
        WAIT = 1'b0,
        RUN  = 1'b1
    } io_start_state_t;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous FIFO with registered occupancy. The read port is the
// registered head entry, so data moves only on clock edges. Callers must
// not pop when empty and must not push when full unless also popping.
module io_out_fifo
    import io_out_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [ptr_width(DEPTH):0]     count
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;

    // Storage array; contents are intentionally not cleared by reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at DEPTH; reset discards everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/io_out_capture.sv
// Captures CPU output-port words into a FIFO, drains them over valid/ready,
// and raises the CPU I/O enable a fixed number of cycles after reset.
module io_out_capture
    import io_out_pkg::*;
#(
    parameter int WIDTH       = 36,
    parameter int DEPTH       = 16,
    parameter int START_DELAY = 10,
    parameter int COUNTWIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      outFlag,
    input  logic [WIDTH-1:0]          out,
    output logic                      startIO,
    output logic                      dataValid,
    input  logic                      dataReady,
    output logic [WIDTH-1:0]          data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    input  logic                      clearOverflow,
    output logic [COUNTWIDTH-1:0]     wordsCaptured
);

    localparam int DCW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    io_start_state_t   state_q, state_d;
    logic [DCW-1:0]    delay_q, delay_d;
    logic              overflow_q, overflow_d;
    logic [COUNTWIDTH-1:0] words_q;

    logic running;
    logic push;
    logic pop;
    logic drop;

    // Start sequencer next-state: count in WAIT, move to RUN on the last tick.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        if (state_q == WAIT) begin
            if (delay_q == DCW'(START_DELAY - 1)) begin
                state_d = RUN;
            end else begin
                delay_d = delay_q + 1'b1;
            end
        end
    end

    // Start sequencer state and delay counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
        end
    end

    assign running   = (state_q == RUN);
    assign startIO   = running;
    assign dataValid = !empty;
    assign pop       = dataValid && dataReady;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = running && outFlag && (!full || pop);
    assign drop      = running && outFlag && full && !pop;

    // Sticky drop flag; a new drop outranks a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end
    end

    // Overflow flag and accepted-word counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            if (push) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

    assign overflow      = overflow_q;
    assign wordsCaptured = words_q;

    io_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (out),
        .rdata (data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_io_out_capture.sv
// Scoreboard bench for io_out_capture with default parameters.
module tb_io_out_capture;

    localparam int WIDTH       = 36;
    localparam int DEPTH       = 16;
    localparam int START_DELAY = 10;
    localparam int COUNTWIDTH  = 16;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  outFlag = 1'b0;
    logic [WIDTH-1:0]      out = '0;
    logic                  startIO;
    logic                  dataValid;
    logic                  dataReady = 1'b0;
    logic [WIDTH-1:0]      data;
    logic                  full;
    logic                  empty;
    logic [4:0]            count;
    logic                  overflow;
    logic                  clearOverflow = 1'b0;
    logic [COUNTWIDTH-1:0] wordsCaptured;

    int checks = 0;
    int errors = 0;

    // Bench-side model state
    logic [WIDTH-1:0]      exp_q[$];
    logic [COUNTWIDTH-1:0] wc_m = '0;
    bit                    ovf_m = 1'b0;
    int                    edges = 0;

    io_out_capture #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .START_DELAY (START_DELAY),
        .COUNTWIDTH  (COUNTWIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .outFlag       (outFlag),
        .out           (out),
        .startIO       (startIO),
        .dataValid     (dataValid),
        .dataReady     (dataReady),
        .data          (data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .clearOverflow (clearOverflow),
        .wordsCaptured (wordsCaptured)
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus, advance the model, and hand back any
    // word the consumer took this cycle together with its expected value.
    task automatic cycle(input logic flag, input logic [WIDTH-1:0] word,
                         input logic rdy, input logic clr,
                         output bit popped, output logic [WIDTH-1:0] got,
                         output logic [WIDTH-1:0] expv);
        bit run_m, pop_m, full_m;
        outFlag       = flag;
        out           = word;
        dataReady     = rdy;
        clearOverflow = clr;
        run_m  = (edges >= START_DELAY);
        pop_m  = (exp_q.size() > 0) && rdy;
        full_m = (exp_q.size() == DEPTH);
        popped = pop_m;
        got    = data;
        expv   = '0;
        if (pop_m) expv = exp_q.pop_front();
        if (run_m && flag && (!full_m || pop_m)) begin
            exp_q.push_back(word);
            wc_m = wc_m + 1'b1;
        end
        if (run_m && flag && full_m && !pop_m) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        @(posedge clock);
        #1;
        edges++;
        outFlag       = 1'b0;
        clearOverflow = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (startIO !== 1'b0) begin errors++; $display("FAIL reset_startIO got=%b exp=0", startIO); end
        checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_dataValid got=%b exp=0", dataValid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (wordsCaptured !== 16'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", wordsCaptured); end
        $display("reset: startIO=%b count=%0d empty=%b", startIO, count, empty);
        reset = 1'b0;
        edges = 0;
    endtask

    task automatic test_start_delay(input string tag);
        bit p; logic [WIDTH-1:0] g, e;
        for (int k = 1; k <= 12; k++) begin
            cycle((k == 5), 36'h5, 1'b0, 1'b0, p, g, e);
            checks++;
            if (startIO !== (k >= START_DELAY)) begin
                errors++;
                $display("FAIL %s_startIO edge=%0d got=%b exp=%b", tag, k, startIO, (k >= START_DELAY));
            end
            $display("%s: edge=%0d startIO=%b", tag, k, startIO);
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL %s_wait_push count got=%0d exp=0", tag, count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s_wait_ovf got=%b exp=0", tag, overflow); end
        checks++; if (wordsCaptured !== 16'd0) begin errors++; $display("FAIL %s_wait_words got=%0d exp=0", tag, wordsCaptured); end
    endtask

    task automatic test_fill();
        bit p; logic [WIDTH-1:0] g, e;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, p, g, e);
            $display("fill: push=0x%0h count=%0d", i, count);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
        checks++; if (wordsCaptured !== 16'd16) begin errors++; $display("FAIL fill_words got=%0d exp=16", wordsCaptured); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, p, g, e);
            checks++;
            if (data !== 36'h1 || dataValid !== 1'b1) begin
                errors++;
                $display("FAIL fill_hold data=0x%0h valid=%b exp data=0x1 valid=1", data, dataValid);
            end
        end
    endtask

    task automatic test_overflow();
        bit p; logic [WIDTH-1:0] g, e;
        cycle(1'b1, 36'hABC, 1'b0, 1'b0, p, g, e);
        $display("overflow: push=0xabc overflow=%b count=%0d", overflow, count);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (wordsCaptured !== 16'd16) begin errors++; $display("FAIL ovf_words got=%0d exp=16", wordsCaptured); end
        cycle(1'b0, '0, 1'b0, 1'b1, p, g, e);
        $display("overflow: clear overflow=%b", overflow);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        cycle(1'b1, 36'hABD, 1'b0, 1'b1, p, g, e);
        $display("overflow: set+clear overflow=%b", overflow);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        cycle(1'b0, '0, 1'b0, 1'b1, p, g, e);
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL ovf_clear2 got=%b exp=%b", overflow, ovf_m); end
    endtask

    task automatic test_full_pushpop();
        bit p; logic [WIDTH-1:0] g, e;
        cycle(1'b1, 36'h77, 1'b1, 1'b0, p, g, e);
        $display("full_pushpop: popped=0x%0h count=%0d", g, count);
        checks++; if (!p || g !== 36'h1) begin errors++; $display("FAIL pp_head got=0x%0h exp=0x1", g); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count got=%0d exp=16", count); end
        checks++; if (wordsCaptured !== 16'd17) begin errors++; $display("FAIL pp_words got=%0d exp=17", wordsCaptured); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        bit p; logic [WIDTH-1:0] g, e;
        int pops = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, p, g, e);
            if (p) begin
                pops++;
                checks++;
                if (g !== e) begin errors++; $display("FAIL drain_data idx=%0d got=0x%0h exp=0x%0h", i, g, e); end
                $display("drain: idx=%0d data=0x%0h exp=0x%0h", i, g, e);
            end
        end
        checks++; if (e !== 36'h77) begin errors++; $display("FAIL drain_last got=0x%0h exp=0x77", e); end
        checks++; if (pops != 16) begin errors++; $display("FAIL drain_pops got=%0d exp=16", pops); end
        checks++; if (empty !== 1'b1 || dataValid !== 1'b0) begin
            errors++; $display("FAIL drain_empty empty=%b valid=%b exp 1/0", empty, dataValid);
        end
    endtask

    task automatic test_wrap();
        bit p; logic [WIDTH-1:0] g, e;
        int pops = 0;
        for (int i = 0; i <= 40; i++) begin
            cycle((i < 40), WIDTH'(i), 1'b1, 1'b0, p, g, e);
            if (p) begin
                pops++;
                checks++;
                if (g !== e) begin errors++; $display("FAIL wrap_data idx=%0d got=0x%0h exp=0x%0h", i, g, e); end
                $display("wrap: idx=%0d data=0x%0h exp=0x%0h", i, g, e);
            end
        end
        checks++; if (pops != 40) begin errors++; $display("FAIL wrap_pops got=%0d exp=40", pops); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        checks++; if (wordsCaptured !== wc_m) begin errors++; $display("FAIL wrap_words got=%0d exp=%0d", wordsCaptured, wc_m); end
    endtask

    task automatic test_reset_mid();
        bit p; logic [WIDTH-1:0] g, e;
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(36'h100 + i), 1'b0, 1'b0, p, g, e);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count_pre got=%0d exp=5", count); end
        #2;
        reset = 1'b1;
        #1;
        $display("reset_mid: count=%0d valid=%b startIO=%b", count, dataValid, startIO);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", dataValid); end
        checks++; if (startIO !== 1'b0) begin errors++; $display("FAIL mid_startIO got=%b exp=0", startIO); end
        checks++; if (wordsCaptured !== 16'd0) begin errors++; $display("FAIL mid_words got=%0d exp=0", wordsCaptured); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        wc_m  = '0;
        ovf_m = 1'b0;
        edges = 0;
        test_start_delay("restart");
    endtask

    initial begin
        test_reset();
        test_start_delay("start");
        test_fill();
        test_overflow();
        test_full_pushpop();
        test_drain();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
